// File: rtl/ff_pulse_arbiter_if.sv
// Request/grant and flip-flop pulse bundle for ff_pulse_arbiter.
// The master side issues requests; the slave side (the arbiter) returns grants and pulses.
interface ff_pulse_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] op;
    logic [NUM_REQ-1:0] gnt;
    logic               in1;
    logic               in2;
    logic               busy;
    logic               ff_shadow;

    modport master (
        output req,
        output op,
        input  gnt,
        input  in1,
        input  in2,
        input  busy,
        input  ff_shadow
    );

    modport slave (
        input  req,
        input  op,
        output gnt,
        output in1,
        output in2,
        output busy,
        output ff_shadow
    );
endinterface

// File: rtl/ff_pulse_arbiter.sv
// Round-robin arbiter that turns set/clear requests into one-cycle in1/in2 flip-flop pulses.
// Optional macro FF_PULSE_REDUNDANT_SKIP_EN: grants whose op matches ff_shadow skip the pulse.
module ff_pulse_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    ff_pulse_arbiter_if.slave bus
);
    localparam int          PW     = $clog2(NUM_REQ);
    localparam logic [PW:0] NREQ_W = (PW+1)'(NUM_REQ);
    localparam logic [3:0]  HOLD_LD = 4'(HOLD_CYCLES);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PULSE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               in1_q, in1_d;
    logic               in2_q, in2_d;
    logic               shadow_q, shadow_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [3:0]         cnt_q, cnt_d;

    logic               win_vld;
    logic [PW-1:0]      win_idx;
    logic [PW:0]        cand;
    logic [PW:0]        win_inc;
    logic [PW-1:0]      ptr_nxt;
    logic               win_op;
    logic               skip;

    // First requester at or above the pointer, wrapping past NUM_REQ-1.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (PW+1)'(k);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!win_vld && bus.req[cand[PW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[PW-1:0];
            end
        end
    end

    assign win_inc = {1'b0, win_idx} + (PW+1)'(1);
    assign ptr_nxt = (win_inc == NREQ_W) ? '0 : win_inc[PW-1:0];
    assign win_op  = bus.op[win_idx];

`ifdef FF_PULSE_REDUNDANT_SKIP_EN
    assign skip = (win_op == shadow_q);
`else
    assign skip = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        gnt_d    = '0;
        in1_d    = 1'b0;
        in2_d    = 1'b0;
        shadow_d = shadow_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    gnt_d[win_idx] = 1'b1;
                    ptr_d          = ptr_nxt;
                    if (!skip) begin
                        in1_d   = win_op;
                        in2_d   = ~win_op;
                        state_d = ST_PULSE;
                    end
                end
            end

            ST_PULSE: begin
                // The flip-flop captures the pulse on this edge, so the shadow follows in1.
                shadow_d = in1_q;
                if (HOLD_CYCLES == 0) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                end
            end

            ST_HOLD: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            in1_q    <= 1'b0;
            in2_q    <= 1'b0;
            shadow_q <= 1'b0;
            ptr_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            in1_q    <= in1_d;
            in2_q    <= in2_d;
            shadow_q <= shadow_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.in1       = in1_q;
    assign bus.in2       = in2_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.ff_shadow = shadow_q;

    a_no_dual_pulse: assert property (@(posedge clk) disable iff (!rst_n) !(in1_q && in2_q));
    a_gnt_onehot:    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
endmodule

// File: tb/tb_ff_pulse_arbiter.sv
// Directed bench for ff_pulse_arbiter at NUM_REQ=4, HOLD_CYCLES=2 (default build).
module tb_ff_pulse_arbiter;
    logic clk;
    logic rst_n;

    ff_pulse_arbiter_if #(.NUM_REQ(4)) bus ();

    ff_pulse_arbiter #(
        .NUM_REQ     (4),
        .HOLD_CYCLES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observed/expected packed as {gnt[3:0], in1, in2, busy, ff_shadow}.
    task automatic expect_out(input string tag, input logic [3:0] g, input logic i1,
                              input logic i2, input logic b, input logic s);
        logic [7:0] obs;
        logic [7:0] exp;
        obs = {bus.gnt, bus.in1, bus.in2, bus.busy, bus.ff_shadow};
        exp = {g, i1, i2, b, s};
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed={gnt,in1,in2,busy,sh}=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] opv;
        logic       sh;
        logic       o;
        int         w;

        n_vec   = 0;
        n_err   = 0;
        sh      = 1'b0;
        rst_n   = 1'b0;
        bus.req = '0;
        bus.op  = '0;

        #20;
        expect_out("reset_hold", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        #30;
        rst_n = 1'b1;

        for (int c = 0; c < 20; c++) begin
            tick();
            expect_out("idle_after_reset", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // All four requesting: grants 0,1,2,3,0 four cycles apart.
        opv     = 4'b0101;
        bus.req = 4'b1111;
        bus.op  = opv;
        for (int g = 0; g < 5; g++) begin
            w = g % 4;
            o = opv[w];
            tick();
            expect_out("rr_pulse", 4'(1 << w), o, ~o, 1'b1, sh);
            if (g == 4) bus.req = '0;
            sh = o;
            tick();
            expect_out("rr_hold1", 4'b0000, 1'b0, 1'b0, 1'b1, sh);
            tick();
            expect_out("rr_hold2", 4'b0000, 1'b0, 1'b0, 1'b1, sh);
            tick();
            expect_out("rr_idle", 4'b0000, 1'b0, 1'b0, 1'b0, sh);
        end

        // Clear request from requester 1 (pointer sits at 1).
        bus.req = 4'b0010;
        bus.op  = 4'b0000;
        tick();
        expect_out("clr_pulse", 4'b0010, 1'b0, 1'b1, 1'b1, 1'b1);
        bus.req = '0;
        tick();
        expect_out("clr_hold1", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        expect_out("clr_hold2", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        expect_out("clr_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Single-cycle set request from requester 0.
        bus.req = 4'b0001;
        bus.op  = 4'b0001;
        tick();
        expect_out("set_pulse", 4'b0001, 1'b1, 1'b0, 1'b1, 1'b0);
        bus.req = '0;
        tick();
        expect_out("set_hold1", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        expect_out("set_hold2", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        expect_out("set_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);

        // req[2] appears only during HOLD and is lost.
        bus.req = 4'b1000;
        bus.op  = 4'b1000;
        tick();
        expect_out("lost_pulse3", 4'b1000, 1'b1, 1'b0, 1'b1, 1'b1);
        bus.req = '0;
        tick();
        expect_out("lost_hold1", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);
        bus.req = 4'b0100;
        bus.op  = 4'b0000;
        tick();
        expect_out("lost_hold2", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);
        bus.req = '0;
        tick();
        expect_out("lost_idle1", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        expect_out("lost_idle2", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset mid-PULSE of a set (pointer at 0, winner 1 moves it to 2).
        bus.req = 4'b0010;
        bus.op  = 4'b0010;
        tick();
        expect_out("abort_pulse", 4'b0010, 1'b1, 1'b0, 1'b1, 1'b1);
        #2;
        rst_n   = 1'b0;
        bus.req = '0;
        #1;
        expect_out("abort_async", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        expect_out("abort_post1", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("abort_post2", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Pointer back at 0: between requesters 1 and 3, 1 wins.
        bus.req = 4'b1010;
        bus.op  = 4'b0000;
        tick();
        expect_out("ptr_reset_win1", 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0);
        bus.req = 4'b1000;
        tick();
        expect_out("ptr_hold1", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        expect_out("ptr_hold2", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        expect_out("ptr_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("req3_alone", 4'b1000, 1'b0, 1'b1, 1'b1, 1'b0);
        bus.req = '0;
        tick();
        expect_out("req3_hold1", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        expect_out("req3_hold2", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        expect_out("req3_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
